// File: rtl/matmul_seq_ctrl.sv
// Control sequencer for the AXI-Stream matrix-vector coprocessor (RES = A x B).
// Loads A then B from the input stream, walks the MAC over every row, then streams
// RES out through a two-entry buffer (RES RAM output register + output data register).
// Handshakes: a beat transfers on a rising ACLK edge where TVALID and TREADY are both high;
// a producer holding TVALID keeps its payload stable until that edge.
module matmul_seq_ctrl #(
  parameter int A_DEPTH_BITS   = 9,
  parameter int B_DEPTH_BITS   = 3,
  parameter int RES_DEPTH_BITS = 6
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  output logic                      A_write_en,
  output logic [A_DEPTH_BITS-1:0]   A_write_address,
  output logic                      B_write_en,
  output logic [B_DEPTH_BITS-1:0]   B_write_address,
  output logic                      A_read_en,
  output logic [A_DEPTH_BITS-1:0]   A_read_address,
  output logic                      B_read_en,
  output logic [B_DEPTH_BITS-1:0]   B_read_address,
  output logic                      mac_en,
  output logic                      mac_first,
  output logic                      RES_write_en,
  output logic [RES_DEPTH_BITS-1:0] RES_write_address,
  output logic                      RES_read_en,
  output logic [RES_DEPTH_BITS-1:0] RES_read_address,
  output logic                      out_load,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_RECV_A    = 3'd0,
    S_RECV_B    = 3'd1,
    S_COMPUTE   = 3'd2,
    S_DRAIN     = 3'd3,
    S_WRITE_OUT = 3'd4
  } state_t;

  state_t                    state;
  logic [A_DEPTH_BITS-1:0]   acnt;
  logic [B_DEPTH_BITS-1:0]   bcnt;
  logic                      s_ready;
  logic                      rd_en_q;
  logic [A_DEPTH_BITS-1:0]   rd_addr;
  logic                      drain_cnt;
  logic [RES_DEPTH_BITS:0]   rd_cnt;
  logic [RES_DEPTH_BITS:0]   ld_cnt;
  logic                      ram_vld;
  logic                      m_valid;
  logic                      m_last;

  logic                      mac_en_q;
  logic                      mac_first_q;
  logic                      row_done_q;
  logic [RES_DEPTH_BITS-1:0] row_q;
  logic                      res_we_q;
  logic [RES_DEPTH_BITS-1:0] res_waddr_q;

  logic s_fire;
  logic m_fire;
  logic res_rd;
  logic load;

  // TLAST on the input is not needed: beats are counted instead.
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;

  // Handshake and buffer-control decodes that must react within the cycle.
  always_comb begin
    s_fire = S_AXIS_TVALID & s_ready;
    m_fire = m_valid & M_AXIS_TREADY;
    // Output register takes the RAM entry when it is empty or being drained now.
    load   = ram_vld & (~m_valid | M_AXIS_TREADY);
    // Read the next word only if the RAM output register is free by the next edge.
    res_rd = (state == S_WRITE_OUT) & ~rd_cnt[RES_DEPTH_BITS] & (~ram_vld | load);
  end

  // Main sequencer: receive A, receive B, issue reads, drain, stream results.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_RECV_A;
      acnt      <= '0;
      bcnt      <= '0;
      s_ready   <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
      rd_cnt    <= '0;
      ld_cnt    <= '0;
      ram_vld   <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      case (state)
        S_RECV_A: begin
          if (s_fire) begin
            if (acnt == '1) begin
              acnt  <= '0;
              state <= S_RECV_B;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end
        end
        S_RECV_B: begin
          if (s_fire) begin
            if (bcnt == '1) begin
              bcnt    <= '0;
              s_ready <= 1'b0;
              rd_en_q <= 1'b1;
              rd_addr <= '0;
              state   <= S_COMPUTE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (rd_addr == '1) begin
            rd_en_q   <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // Two cycles: the last MAC, then the row-63 RES write.
          if (drain_cnt) begin
            state <= S_WRITE_OUT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_WRITE_OUT: begin
          if (res_rd) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
          if (res_rd) begin
            ram_vld <= 1'b1;
          end else if (load) begin
            ram_vld <= 1'b0;
          end
          if (load) begin
            m_valid <= 1'b1;
            m_last  <= ~ld_cnt[RES_DEPTH_BITS] & (ld_cnt[RES_DEPTH_BITS-1:0] == '1);
            ld_cnt  <= ld_cnt + 1'b1;
          end else if (m_fire) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
          if (m_fire && m_last) begin
            state   <= S_RECV_A;
            s_ready <= 1'b1;
            rd_cnt  <= '0;
            ld_cnt  <= '0;
            ram_vld <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
        end
        default: state <= S_RECV_A;
      endcase
    end
  end

  // MAC and RES-write pipeline trailing each read issue by one and two cycles.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      row_done_q  <= 1'b0;
      row_q       <= '0;
      res_we_q    <= 1'b0;
      res_waddr_q <= '0;
    end else begin
      mac_en_q    <= rd_en_q;
      mac_first_q <= rd_en_q & (rd_addr[B_DEPTH_BITS-1:0] == '0);
      row_done_q  <= rd_en_q & (rd_addr[B_DEPTH_BITS-1:0] == '1);
      row_q       <= rd_addr[A_DEPTH_BITS-1:B_DEPTH_BITS];
      res_we_q    <= row_done_q;
      res_waddr_q <= row_q;
    end
  end

  assign S_AXIS_TREADY     = s_ready;
  assign A_write_en        = s_fire & (state == S_RECV_A);
  assign A_write_address   = acnt;
  assign B_write_en        = s_fire & (state == S_RECV_B);
  assign B_write_address   = bcnt;
  assign A_read_en         = rd_en_q;
  assign A_read_address    = rd_addr;
  assign B_read_en         = rd_en_q;
  assign B_read_address    = rd_addr[B_DEPTH_BITS-1:0];
  assign mac_en            = mac_en_q;
  assign mac_first         = mac_first_q;
  assign RES_write_en      = res_we_q;
  assign RES_write_address = res_waddr_q;
  assign RES_read_en       = res_rd;
  assign RES_read_address  = rd_cnt[RES_DEPTH_BITS-1:0];
  assign out_load          = load;
  assign M_AXIS_TVALID     = m_valid;
  assign M_AXIS_TLAST      = m_last;
  assign state_dbg         = state;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: models the A/B/RES RAMs, MAC and output register around the
// controller and compares the streamed results with row dot products computed directly.
module tb_matmul_seq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        A_write_en;
  logic [8:0]  A_write_address;
  logic        B_write_en;
  logic [2:0]  B_write_address;
  logic        A_read_en;
  logic [8:0]  A_read_address;
  logic        B_read_en;
  logic [2:0]  B_read_address;
  logic        mac_en;
  logic        mac_first;
  logic        RES_write_en;
  logic [5:0]  RES_write_address;
  logic        RES_read_en;
  logic [5:0]  RES_read_address;
  logic        out_load;
  logic [2:0]  state_dbg;
  logic [7:0]  s_tdata;

  matmul_seq_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .A_write_en(A_write_en), .A_write_address(A_write_address),
    .B_write_en(B_write_en), .B_write_address(B_write_address),
    .A_read_en(A_read_en), .A_read_address(A_read_address),
    .B_read_en(B_read_en), .B_read_address(B_read_address),
    .mac_en(mac_en), .mac_first(mac_first),
    .RES_write_en(RES_write_en), .RES_write_address(RES_write_address),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
    .out_load(out_load), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [7:0]  a_ram [512];
  logic [7:0]  b_ram [8];
  logic [7:0]  a_rd, b_rd;
  logic [31:0] acc, res_ram [64], res_rd, out_reg;

  always @(posedge ACLK) begin
    if (A_write_en) a_ram[A_write_address] <= s_tdata;
    if (B_write_en) b_ram[B_write_address] <= s_tdata;
    if (A_read_en) a_rd <= a_ram[A_read_address];
    if (B_read_en) b_rd <= b_ram[B_read_address];
    if (mac_en) acc <= mac_first ? 32'(a_rd) * 32'(b_rd) : acc + 32'(a_rd) * 32'(b_rd);
    if (RES_write_en) res_ram[RES_write_address] <= acc;
    if (RES_read_en) res_rd <= res_ram[RES_read_address];
    if (out_load) out_reg <= res_rd;
  end

  // ---------------- reference model ----------------
  logic [7:0]  a_data [512];
  logic [7:0]  b_data [8];
  logic [31:0] gold [64];
  int job_id = 0;
  int rdy_mode = 0;

  task automatic start_job(input int pattern);
    for (int i = 0; i < 512; i++) a_data[i] = (pattern == 0) ? 8'(i / 8) : 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++)   b_data[k] = (pattern == 0) ? 8'(k + 1) : 8'($urandom_range(0, 255));
    for (int r = 0; r < 64; r++) begin
      int s = 0;
      for (int k = 0; k < 8; k++) s += int'(a_data[r * 8 + k]) * int'(b_data[k]);
      gold[r] = 32'(s);
    end
    job_id++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q [$];
  int seen_id = 0;
  int a_wr_n, a_wr_bad, b_wr_n, b_wr_bad, gap_bad, rd_n, rd_bad, mac_n, mac_bad;
  int resw_n, resw_bad, resr_bad, out_idx;
  int last_in_cyc, first_rd_cyc, first_tv_cyc;
  bit got_rd, got_tv, prev_stall, hold_last;
  logic [31:0] hold_data;
  bit res_written [64];

  initial begin
    forever begin
      @(negedge ACLK);
      if (seen_id != job_id) begin
        seen_id = job_id;
        a_wr_n = 0; a_wr_bad = 0; b_wr_n = 0; b_wr_bad = 0; gap_bad = 0;
        rd_n = 0; rd_bad = 0; mac_n = 0; mac_bad = 0; resw_n = 0; resw_bad = 0;
        resr_bad = 0; out_idx = 0; got_rd = 0; got_tv = 0; prev_stall = 0;
        last_in_cyc = 0; first_rd_cyc = 0; first_tv_cyc = 0;
        for (int r = 0; r < 64; r++) res_written[r] = 0;
        exp_q.delete();
        for (int r = 0; r < 64; r++) exp_q.push_back(gold[r]);
      end
      if (!ARESETN) begin
        prev_stall = 0;
      end else begin
        if (!S_AXIS_TVALID && (A_write_en || B_write_en)) gap_bad++;
        if (A_write_en) begin
          if (A_write_address != 9'(a_wr_n)) a_wr_bad++;
          a_wr_n++;
        end
        if (B_write_en) begin
          if (B_write_address != 3'(b_wr_n)) b_wr_bad++;
          if (b_wr_n == 7) last_in_cyc = cyc;
          b_wr_n++;
        end
        if (A_read_en || B_read_en) begin
          if (!(A_read_en && B_read_en) || A_read_address != 9'(rd_n) || B_read_address != 3'(rd_n % 8))
            rd_bad++;
          rd_n++;
        end
        if (mac_first && !mac_en) mac_bad++;
        if (mac_en) begin
          if (mac_first != ((mac_n % 8) == 0)) mac_bad++;
          mac_n++;
        end
        if (RES_read_en) begin
          if (!res_written[RES_read_address]) resr_bad++;
          if (!got_rd) begin got_rd = 1; first_rd_cyc = cyc; end
        end
        if (RES_write_en) begin
          if (RES_write_address != 6'(resw_n)) resw_bad++;
          res_written[RES_write_address] = 1;
          resw_n++;
        end
        if (M_AXIS_TVALID) begin
          if (!got_tv) begin got_tv = 1; first_tv_cyc = cyc; end
          if (prev_stall) begin
            check("hold_data", out_reg, hold_data);
            check("hold_last", 32'(M_AXIS_TLAST), 32'(hold_last));
          end
          if (M_AXIS_TREADY) begin
            if (exp_q.size() == 0) begin
              check("out_extra", 32'(out_idx), 32'd64);
            end else begin
              logic [31:0] e;
              e = exp_q.pop_front();
              check("out_data", out_reg, e);
              check("out_last", 32'(M_AXIS_TLAST), 32'(out_idx == 63));
            end
            out_idx++;
          end
          prev_stall = !M_AXIS_TREADY;
          hold_data  = out_reg;
          hold_last  = M_AXIS_TLAST;
        end else begin
          if (prev_stall) check("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
          prev_stall = 0;
        end
      end
    end
  end

  // ---------------- output-side ready driver ----------------
  initial begin
    int rseen = 0;
    int stall_left = 0;
    bit s3 = 0, s62 = 0;
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      if (rseen != job_id) begin
        rseen = job_id; s3 = 0; s62 = 0; stall_left = 0;
      end
      case (rdy_mode)
        0: M_AXIS_TREADY = 1'b1;
        1: M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_idx == 3 && !s3)   begin s3 = 1;  stall_left = 1; end
          if (out_idx == 62 && !s62) begin s62 = 1; stall_left = 5; end
          if (stall_left > 0) begin
            M_AXIS_TREADY = 1'b0;
            stall_left--;
          end else begin
            M_AXIS_TREADY = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    S_AXIS_TVALID = 1'b0;
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int guard = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TLAST  = last;
    s_tdata       = d;
    @(negedge ACLK);
    while (!S_AXIS_TREADY && guard < 100) begin @(negedge ACLK); guard++; end
    if (!S_AXIS_TREADY) check("s_tready_timeout", 32'(S_AXIS_TREADY), 32'd1);
    @(posedge ACLK);
    #1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  // gap mode 0: contiguous, 1: fixed gaps, 2: random gaps
  task automatic send_inputs(input int gm);
    for (int i = 0; i < 512; i++) begin
      send_beat(a_data[i], 1'b0);
      if (gm == 1 && i == 2) idle(2);
      if (gm == 2 && i < 511 && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    for (int k = 0; k < 8; k++) begin
      send_beat(b_data[k], k == 7);
      if (gm == 1 && k == 3) idle(1);
      if (gm == 2 && k < 7 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_s_tready"}, 32'(S_AXIS_TREADY), 32'd1);
    check({where, "_enables"}, {21'b0, A_write_en, B_write_en, A_read_en, B_read_en, mac_en,
          mac_first, RES_write_en, RES_read_en, out_load, M_AXIS_TVALID, M_AXIS_TLAST}, 32'd0);
    check({where, "_addrs"}, {8'b0, A_write_address, B_write_address, A_read_address, B_read_address}, 32'd0);
    check({where, "_res_addrs"}, {20'b0, RES_write_address, RES_read_address}, 32'd0);
  endtask

  task automatic do_abort(input string where);
    @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    check_reset_outputs(where);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (out_idx < 64 && guard < 4000) begin @(negedge ACLK); guard++; end
    check("out_count", 32'(out_idx), 32'd64);
    @(negedge ACLK);
    check("end_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("end_s_tready", 32'(S_AXIS_TREADY), 32'd1);
    check("exp_left", 32'(exp_q.size()), 32'd0);
    check("a_wr_count", 32'(a_wr_n), 32'd512);
    check("a_wr_addr_bad", 32'(a_wr_bad), 32'd0);
    check("b_wr_count", 32'(b_wr_n), 32'd8);
    check("b_wr_addr_bad", 32'(b_wr_bad), 32'd0);
    check("gap_write_bad", 32'(gap_bad), 32'd0);
    check("rd_count", 32'(rd_n), 32'd512);
    check("rd_addr_bad", 32'(rd_bad), 32'd0);
    check("mac_count", 32'(mac_n), 32'd512);
    check("mac_first_bad", 32'(mac_bad), 32'd0);
    check("res_wr_count", 32'(resw_n), 32'd64);
    check("res_wr_addr_bad", 32'(resw_bad), 32'd0);
    check("res_rd_early", 32'(resr_bad), 32'd0);
    check("first_rd_latency", 32'(first_rd_cyc - last_in_cyc), 32'd515);
    check("tvalid_latency", 32'(first_tv_cyc - last_in_cyc), 32'd517);
    @(posedge ACLK);
    #1;
  endtask

  task automatic run_job(input int pattern, input int gm, input int rm);
    rdy_mode = rm;
    start_job(pattern);
    send_inputs(gm);
    wait_done();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    ARESETN       = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    s_tdata       = 8'd0;
    #3 ARESETN = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    run_job(0, 0, 0);   // fixed data, contiguous input, always ready
    run_job(1, 1, 0);   // input gaps
    run_job(1, 0, 2);   // output stalls at beats 3 and 62
    run_job(1, 2, 1);   // random gaps and random ready, back-to-back with next
    run_job(1, 0, 0);

    // abort during COMPUTE once row 20 is written
    begin
      int guard = 0;
      rdy_mode = 0;
      start_job(1);
      send_inputs(0);
      while (resw_n <= 20 && guard < 2000) begin @(negedge ACLK); guard++; end
      check("abort_compute_reach", 32'(resw_n > 20), 32'd1);
      do_abort("abort_compute");
    end
    run_job(1, 0, 0);

    // abort during WRITE_OUT at output beat 10
    begin
      int guard = 0;
      rdy_mode = 0;
      start_job(1);
      send_inputs(0);
      while (out_idx < 10 && guard < 2000) begin @(negedge ACLK); guard++; end
      check("abort_out_reach", 32'(out_idx >= 10), 32'd1);
      do_abort("abort_out");
    end
    run_job(1, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
